// File: rtl/filter_pkg.sv
// filter_pkg: shared definitions for the filter_cascade block.
//   - state_t       : sequencer states (IDLE / MAC1 / MAC2 / DONE)
//   - SAT_EN        : 1 when FILTER_SAT_EN is defined (section outputs clamp), else 0 (wrap)
//   - shift_c1/c2   : Q-format shifts for c1 (Q2.(CW-2)) and c2 (Q1.(CW-1))
//   - reduce_sample : DW+2 -> DW reduction (clamp when sat, otherwise the caller truncates = wrap)
//   - clamps        : 1 when reduce_sample would clamp
// Configuration macro: FILTER_SAT_EN
package filter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC1 = 2'd1,
        S_MAC2 = 2'd2,
        S_DONE = 2'd3
    } state_t;

`ifdef FILTER_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    function automatic int shift_c1(input int cw);
        return cw - 2;
    endfunction

    function automatic int shift_c2(input int cw);
        return cw - 1;
    endfunction

    // Values are carried in 64 bits so one function serves any DW up to 62.
    function automatic logic signed [63:0] reduce_sample(input logic signed [63:0] s,
                                                         input int dw, input logic sat);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sat && (s > hi)) return hi;
        if (sat && (s < lo)) return lo;
        return s;
    endfunction

    function automatic logic clamps(input logic signed [63:0] s, input int dw, input logic sat);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return sat && ((s > hi) || (s < lo));
    endfunction

endpackage

// File: rtl/filter_mac.sv
// filter_mac: the single multiply/accumulate unit shared by every section.
//   clk, rst : clock, async active-high reset
//   first    : MAC1 cycle -> acc <= x + (coef*hist >>> (CW-2))
//   second   : MAC2 cycle -> selects the (CW-1) shift; y/sat valid this cycle
//   x        : section input sample
//   coef     : c1 (MAC1) or c2 (MAC2), signed CW
//   hist     : y1 (MAC1) or y2 (MAC2), signed DW
//   y        : reduced section output (acc + c2*y2 term), signed DW
//   sat      : y was clamped (only possible with FILTER_SAT_EN)
module filter_mac
    import filter_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 first,
    input  logic                 second,
    input  logic signed [DW-1:0] x,
    input  logic signed [CW-1:0] coef,
    input  logic signed [DW-1:0] hist,
    output logic signed [DW-1:0] y,
    output logic                 sat
);

    logic signed [DW+CW-1:0] prod;
    logic signed [DW+1:0]    term;
    logic signed [DW+1:0]    acc;
    logic signed [DW+1:0]    sum;
    logic signed [63:0]      sum_wide;

    // Full-precision product; shifted term always fits DW+2 bits.
    assign prod = $signed({{DW{coef[CW-1]}}, coef}) * $signed({{CW{hist[DW-1]}}, hist});
    assign term = (DW+2)'(second ? (prod >>> shift_c2(CW)) : (prod >>> shift_c1(CW)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (first)
            acc <= {{2{x[DW-1]}}, x} + term;
    end

    // Sum wraps in DW+2 bits before the reduce.
    assign sum      = acc + term;
    assign sum_wide = 64'(sum);
    assign y        = DW'(reduce_sample(sum_wide, DW, SAT_EN));
    assign sat      = clamps(sum_wide, DW, SAT_EN);

endmodule

// File: rtl/filter_cascade.sv
// filter_cascade: NSECT cascaded two-pole all-pole sections, one shared MAC,
// two cycles per section, one sample per start.
//   clk          : clock
//   rst          : async active-high reset
//   coef_in      : coefficient data (signed CW)
//   coef_load    : write coef_in at the write pointer (IDLE only); pointer 0/1 = sect1 c1/c2 ...
//   clear_state  : zero all section history (IDLE only; applied before a coincident start)
//   sig_in       : input sample, captured on accepted start
//   start        : process one sample (IDLE only; loses to coef_load)
//   sig_out      : filtered sample, updated with done
//   done         : one-cycle pulse, sig_out updated
//   busy         : accepted start through the done cycle
//   ovf          : a section clamped during the last sample (FILTER_SAT_EN), else 0
// Configuration macro: FILTER_SAT_EN (clamp section outputs instead of wrapping).
module filter_cascade
    import filter_pkg::*;
#(
    parameter int DW    = 16,
    parameter int CW    = 10,
    parameter int NSECT = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] coef_in,
    input  logic          coef_load,
    input  logic          clear_state,
    input  logic [DW-1:0] sig_in,
    input  logic          start,
    output logic [DW-1:0] sig_out,
    output logic          done,
    output logic          busy,
    output logic          ovf
);

    localparam int SW = (NSECT > 1) ? $clog2(NSECT) : 1;
    localparam int PW = $clog2(2 * NSECT + 1);
    localparam logic [SW-1:0] LAST = SW'(NSECT - 1);
    localparam logic [PW-1:0] PEND = PW'(2 * NSECT);

    state_t state, nstate;
    logic [SW-1:0] sect;
    logic [PW-1:0] ptr;

    logic signed [CW-1:0] c1 [NSECT];
    logic signed [CW-1:0] c2 [NSECT];
    logic signed [DW-1:0] y1 [NSECT];
    logic signed [DW-1:0] y2 [NSECT];

    logic signed [DW-1:0] x;
    logic signed [DW-1:0] mac_y;
    logic                 mac_sat;
    logic                 idle, accept, mac1, mac2;

    // done is registered and lands after the FSM is back in IDLE, so it is
    // folded into busy to keep start/coef_load/clear blocked in the done cycle.
    assign busy   = (state != S_IDLE) || done;
    assign idle   = !busy;
    assign accept = idle && start && !coef_load;
    assign mac1   = (state == S_MAC1);
    assign mac2   = (state == S_MAC2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (accept) nstate = S_MAC1;
            S_MAC1:  nstate = S_MAC2;
            S_MAC2:  nstate = (sect == LAST) ? S_DONE : S_MAC1;
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    filter_mac #(.DW(DW), .CW(CW)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .first  (mac1),
        .second (mac2),
        .x      (x),
        .coef   (mac2 ? c2[sect] : c1[sect]),
        .hist   (mac2 ? y2[sect] : y1[sect]),
        .y      (mac_y),
        .sat    (mac_sat)
    );

    // Sequencing: x carries the running sample from section to section.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sect    <= '0;
            x       <= '0;
            sig_out <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                x    <= sig_in;
                sect <= '0;
            end
            if (mac2) begin
                x <= mac_y;
                if (sect != LAST)
                    sect <= sect + 1'b1;
            end
            if (state == S_DONE) begin
                sig_out <= x;
                done    <= 1'b1;
            end
        end
    end

    // Coefficient and history storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            for (int k = 0; k < NSECT; k++) begin
                c1[k] <= '0;
                c2[k] <= '0;
                y1[k] <= '0;
                y2[k] <= '0;
            end
        end else begin
            if (idle) begin
                if (clear_state) begin
                    for (int k = 0; k < NSECT; k++) begin
                        y1[k] <= '0;
                        y2[k] <= '0;
                    end
                end
                if (coef_load) begin
                    // No match past 2*NSECT-1: the write is dropped.
                    for (int k = 0; k < NSECT; k++) begin
                        if (ptr == PW'(2 * k))     c1[k] <= coef_in;
                        if (ptr == PW'(2 * k + 1)) c2[k] <= coef_in;
                    end
                    if (ptr != PEND)
                        ptr <= ptr + 1'b1;
                end
            end
            if (!coef_load)
                ptr <= '0;
            if (mac2) begin
                y1[sect] <= mac_y;
                y2[sect] <= y1[sect];
            end
        end
    end

`ifdef FILTER_SAT_EN
    logic sat_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_acc <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (accept) begin
                sat_acc <= 1'b0;
                ovf     <= 1'b0;
            end
            if (mac2)
                sat_acc <= sat_acc | mac_sat;
            if (state == S_DONE)
                ovf <= sat_acc;
        end
    end
`else
    // Without saturation the MAC never clamps.
    logic sat_unused;
    assign sat_unused = mac_sat;
    assign ovf        = 1'b0;
`endif

endmodule
